hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the stall-cycle counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port imem_resp  input  1  fetch for current PC complete; held high while the PC is unchanged.
REQ-005 SHALL have port dmem_req  input  1  MEM stage holds a load or store.
REQ-006 SHALL have port dmem_resp  input  1  data access complete.
REQ-007 SHALL have port ex_mem_read  input  1  EX instruction is a load.
REQ-008 SHALL have ports ex_rd, id_rs1, id_rs2  input  5 each  register indices.
REQ-009 SHALL have ports id_rs1_used, id_rs2_used  input  1 each  ID instruction reads rs1/rs2.
REQ-010 SHALL have port ex_br_taken  input  1  EX resolved a taken branch or jump.
REQ-011 SHALL have port ex_br_target  input  32  redirect address from EX.
REQ-012 SHALL have ports load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  output  1 each  stage-register load enables.
REQ-013 SHALL have ports flush_if_id, bubble_id_ex  output  1 each  load zero/NOP into IF/ID or ID/EX instead of the upstream value.
REQ-014 SHALL have ports redirect_valid (output, 1) and redirect_target (output, 32); when valid, PC loads the target.
REQ-015 SHALL have port stall_count  output  CNT_W  stall-cycle count.

Function
REQ-016 SHALL define dmem_stall = dmem_req & ~dmem_resp; load_use = ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
REQ-017 SHALL implement FSM states RUN and SQUASH; all outputs combinational from state and inputs.
REQ-018 RUN priority 1, dmem_stall: all five loads 0, flush/bubble 0, redirect_valid 0, ex_br_taken ignored, state unchanged.
REQ-019 RUN priority 2, ex_br_taken & imem_resp: all loads 1, flush_if_id 1, bubble_id_ex 1, redirect_valid 1, redirect_target = ex_br_target.
REQ-020 RUN priority 3, ex_br_taken & ~imem_resp: capture ex_br_target into target buffer, next state SQUASH, load_pc 0, load_if_id 1 with flush_if_id 1, bubble_id_ex 1, downstream loads 1.
REQ-021 RUN priority 4, load_use: load_pc 0, load_if_id 0, bubble_id_ex 1, load_id_ex/ex_mem/mem_wb 1.
REQ-022 RUN priority 5, ~imem_resp: identical outputs to REQ-021.
REQ-023 RUN otherwise: all loads 1, flush/bubble/redirect_valid 0.
REQ-024 SQUASH & ~imem_resp: load_pc 0, load_if_id 0, bubble_id_ex 1; downstream loads = ~dmem_stall.
REQ-025 SQUASH & imem_resp (regardless of dmem_stall): load_pc 1, redirect_valid 1, redirect_target = buffer, load_if_id 1 with flush_if_id 1, bubble_id_ex 1, downstream loads = ~dmem_stall, next state RUN.
REQ-026 SHALL ignore ex_br_taken in SQUASH (EX holds only bubbles); assertion flags violation.
REQ-027 redirect_target SHALL equal the buffer in SQUASH, ex_br_target otherwise.

Reset
REQ-028 rst SHALL force state RUN, target buffer 0, stall_count 0; rst has priority over every other input.
REQ-029 rst in SQUASH SHALL discard pending redirect; first post-reset cycle follows RUN rules.

Configuration
REQ-030 With PERF_CNT_EN defined, stall_count SHALL increment by 1 each non-reset cycle where load_pc==0, saturating at all-ones.
REQ-031 Without PERF_CNT_EN, stall_count SHALL be constant 0 and no counter flops exist.

Structure
REQ-032 hazard_state_t enum (RUN, SQUASH) SHALL live in package rv32i_types.
REQ-033 Saturating counter SHALL be sub-module sat_counter (CNT_W parameter, clk, rst, inc, count).

Verification
REQ-034 Load-use: ex_mem_read=1, ex_rd=5, id_rs1_used=1, id_rs1=5 -> load_pc=0, load_if_id=0, bubble_id_ex=1, load_mem_wb=1; ex_rd=0 -> no stall.
REQ-035 dmem_req=1, dmem_resp=0 for 3 cycles plus ex_br_taken=1 -> all loads 0 three cycles, no redirect; dmem_resp=1 -> redirect_valid=1.
REQ-036 Branch with imem_resp=0, target 0x60 -> SQUASH; imem_resp=1 two cycles later -> redirect_valid=1, target 0x60, flush_if_id=1, state RUN.
REQ-037 In SQUASH, imem_resp=1 with dmem_stall=1 -> load_pc=1, load_ex_mem=0, state RUN next cycle.
REQ-038 rst asserted in SQUASH -> RUN next cycle, redirect_valid=0, stall_count=0.
REQ-039 PERF_CNT_EN, CNT_W=4: 20 stall cycles -> stall_count=15; without macro -> 0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the RV32I pipeline hazard logic: the hazard FSM state
// and a register-dependency helper.
package rv32i_types;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } hazard_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    function automatic logic src_matches(input logic       used,
                                         input logic [4:0] src,
                                         input logic [4:0] rd);
        return used && (src == rd);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory stalls, load-use interlock and branch
// redirect, including redirects deferred until the pending fetch completes.
// Define PERF_CNT_EN to build the stall-cycle counter; otherwise stall_count is 0.
module hazard_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_br_taken,
    input  logic [31:0]      ex_br_target,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             redirect_valid,
    output logic [31:0]      redirect_target,
    output logic [CNT_W-1:0] stall_count
);

    hazard_state_t state, next_state;
    logic [31:0]   target_buf, next_target_buf;
    logic          dmem_stall;
    logic          load_use;

    assign dmem_stall = dmem_req & ~dmem_resp;
    assign load_use   = ex_mem_read && (ex_rd != REG_X0) &&
                        (src_matches(id_rs1_used, id_rs1, ex_rd) ||
                         src_matches(id_rs2_used, id_rs2, ex_rd));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            target_buf <= '0;
        end else begin
            state      <= next_state;
            target_buf <= next_target_buf;
        end
    end

    // A taken branch that lands while the fetch is still outstanding cannot
    // redirect the PC yet; park the target and squash until the fetch returns.
    always_comb begin
        next_state      = state;
        next_target_buf = target_buf;
        load_pc         = 1'b1;
        load_if_id      = 1'b1;
        load_id_ex      = 1'b1;
        load_ex_mem     = 1'b1;
        load_mem_wb     = 1'b1;
        flush_if_id     = 1'b0;
        bubble_id_ex    = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = (state == SQUASH) ? target_buf : ex_br_target;

        case (state)
            RUN: begin
                if (dmem_stall) begin
                    load_pc     = 1'b0;
                    load_if_id  = 1'b0;
                    load_id_ex  = 1'b0;
                    load_ex_mem = 1'b0;
                    load_mem_wb = 1'b0;
                end else if (ex_br_taken && imem_resp) begin
                    flush_if_id    = 1'b1;
                    bubble_id_ex   = 1'b1;
                    redirect_valid = 1'b1;
                end else if (ex_br_taken) begin
                    next_target_buf = ex_br_target;
                    next_state      = SQUASH;
                    load_pc         = 1'b0;
                    flush_if_id     = 1'b1;
                    bubble_id_ex    = 1'b1;
                end else if (load_use || !imem_resp) begin
                    load_pc      = 1'b0;
                    load_if_id   = 1'b0;
                    bubble_id_ex = 1'b1;
                end
            end

            SQUASH: begin
                load_id_ex   = ~dmem_stall;
                load_ex_mem  = ~dmem_stall;
                load_mem_wb  = ~dmem_stall;
                bubble_id_ex = 1'b1;
                if (imem_resp) begin
                    redirect_valid = 1'b1;
                    flush_if_id    = 1'b1;
                    next_state     = RUN;
                end else begin
                    load_pc    = 1'b0;
                    load_if_id = 1'b0;
                end
            end

            default: begin
                next_state = RUN;
            end
        endcase
    end

    // EX only holds bubbles while squashing, so a taken branch there is an upstream bug.
    squash_no_branch: assert property (@(posedge clk) disable iff (rst)
        (state == SQUASH) |-> !ex_br_taken);

`ifdef PERF_CNT_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~load_pc),
        .count (stall_count)
    );
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (CNT_W=4 to reach saturation quickly).
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             imem_resp, dmem_req, dmem_resp, ex_mem_read;
    logic [4:0]       ex_rd, id_rs1, id_rs2;
    logic             id_rs1_used, id_rs2_used, ex_br_taken;
    logic [31:0]      ex_br_target;
    logic             load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic             flush_if_id, bubble_id_ex, redirect_valid;
    logic [31:0]      redirect_target;
    logic [CNT_W-1:0] stall_count;
    logic [4:0]       loads;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef PERF_CNT_EN
    localparam logic [CNT_W-1:0] EXP_CNT3  = 4'd3;
    localparam logic [CNT_W-1:0] EXP_CNT20 = 4'd15;
`else
    localparam logic [CNT_W-1:0] EXP_CNT3  = 4'd0;
    localparam logic [CNT_W-1:0] EXP_CNT20 = 4'd0;
`endif

    assign loads = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_resp       (imem_resp),
        .dmem_req        (dmem_req),
        .dmem_resp       (dmem_resp),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_br_taken     (ex_br_taken),
        .ex_br_target    (ex_br_target),
        .load_pc         (load_pc),
        .load_if_id      (load_if_id),
        .load_id_ex      (load_id_ex),
        .load_ex_mem     (load_ex_mem),
        .load_mem_wb     (load_mem_wb),
        .flush_if_id     (flush_if_id),
        .bubble_id_ex    (bubble_id_ex),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall_count     (stall_count)
    );

    task automatic applyStimulus_idle();
        imem_resp    = 1'b1;
        dmem_req     = 1'b0;
        dmem_resp    = 1'b0;
        ex_mem_read  = 1'b0;
        ex_rd        = 5'd0;
        id_rs1       = 5'd0;
        id_rs2       = 5'd0;
        id_rs1_used  = 1'b0;
        id_rs2_used  = 1'b0;
        ex_br_taken  = 1'b0;
        ex_br_target = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        applyStimulus_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests_run++;
        if (stall_count !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_count: got %0d expected 0", stall_count);
        end
        tests_run++;
        if (loads !== 5'b11111 || redirect_valid !== 1'b0 || flush_if_id !== 1'b0 || bubble_id_ex !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: loads=%b rv=%b fl=%b bb=%b expected 11111 0 0 0",
                     loads, redirect_valid, flush_if_id, bubble_id_ex);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1_used = 1'b1; id_rs1 = 5'd5;
        @(negedge clk);
        tests_run++;
        if (loads !== 5'b00111 || bubble_id_ex !== 1'b1 || flush_if_id !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_use_rs1: loads=%b bb=%b fl=%b expected 00111 1 0", loads, bubble_id_ex, flush_if_id);
        end
        step();
        id_rs1_used = 1'b0; id_rs1 = 5'd5; id_rs2_used = 1'b1; id_rs2 = 5'd5;
        @(negedge clk);
        tests_run++;
        if (loads !== 5'b00111 || bubble_id_ex !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL load_use_rs2: loads=%b bb=%b expected 00111 1", loads, bubble_id_ex);
        end
        step();
        id_rs2_used = 1'b0;
        @(negedge clk);
        tests_run++;
        if (loads !== 5'b11111 || bubble_id_ex !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_use_unused_src: loads=%b bb=%b expected 11111 0", loads, bubble_id_ex);
        end
        step();
        ex_rd = 5'd0; id_rs1_used = 1'b1; id_rs1 = 5'd0;
        @(negedge clk);
        tests_run++;
        if (loads !== 5'b11111 || bubble_id_ex !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_use_x0: loads=%b bb=%b expected 11111 0", loads, bubble_id_ex);
        end
        step();
        ex_rd = 5'd7; id_rs1 = 5'd6; id_rs2_used = 1'b1; id_rs2 = 5'd8;
        @(negedge clk);
        tests_run++;
        if (loads !== 5'b11111 || bubble_id_ex !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_use_nomatch: loads=%b bb=%b expected 11111 0", loads, bubble_id_ex);
        end
        step();
        ex_mem_read = 1'b0; ex_rd = 5'd6;
        @(negedge clk);
        tests_run++;
        if (loads !== 5'b11111) begin
            tests_failed++;
            $display("[TB] FAIL no_load_match: loads=%b expected 11111", loads);
        end
        step();
    endtask

    task automatic test_dmem_stall();
        do_reset();
        dmem_req = 1'b1; dmem_resp = 1'b0; ex_br_taken = 1'b1; ex_br_target = 32'h40;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (loads !== 5'b00000 || redirect_valid !== 1'b0 || flush_if_id !== 1'b0 || bubble_id_ex !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL dmem_stall_cycle%0d: loads=%b rv=%b fl=%b bb=%b expected 00000 0 0 0",
                         i, loads, redirect_valid, flush_if_id, bubble_id_ex);
            end
            step();
        end
        dmem_resp = 1'b1;
        @(negedge clk);
        tests_run++;
        if (loads !== 5'b11111 || redirect_valid !== 1'b1 || redirect_target !== 32'h40 ||
            flush_if_id !== 1'b1 || bubble_id_ex !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL dmem_release_redirect: loads=%b rv=%b tgt=%h fl=%b bb=%b expected 11111 1 00000040 1 1",
                     loads, redirect_valid, redirect_target, flush_if_id, bubble_id_ex);
        end
        applyStimulus_idle();
        step();
    endtask

    task automatic test_squash();
        do_reset();
        imem_resp = 1'b0; ex_br_taken = 1'b1; ex_br_target = 32'h60;
        @(negedge clk);
        tests_run++;
        if (loads !== 5'b01111 || flush_if_id !== 1'b1 || bubble_id_ex !== 1'b1 || redirect_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL squash_enter: loads=%b fl=%b bb=%b rv=%b expected 01111 1 1 0",
                     loads, flush_if_id, bubble_id_ex, redirect_valid);
        end
        step();
        ex_br_taken = 1'b0; ex_br_target = 32'h99;
        @(negedge clk);
        tests_run++;
        if (loads !== 5'b00111 || bubble_id_ex !== 1'b1 || redirect_valid !== 1'b0 || redirect_target !== 32'h60) begin
            tests_failed++;
            $display("[TB] FAIL squash_wait: loads=%b bb=%b rv=%b tgt=%h expected 00111 1 0 00000060",
                     loads, bubble_id_ex, redirect_valid, redirect_target);
        end
        step();
        imem_resp = 1'b1;
        @(negedge clk);
        tests_run++;
        if (loads !== 5'b11111 || redirect_valid !== 1'b1 || redirect_target !== 32'h60 ||
            flush_if_id !== 1'b1 || bubble_id_ex !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL squash_redirect: loads=%b rv=%b tgt=%h fl=%b bb=%b expected 11111 1 00000060 1 1",
                     loads, redirect_valid, redirect_target, flush_if_id, bubble_id_ex);
        end
        step();
        @(negedge clk);
        tests_run++;
        if (loads !== 5'b11111 || redirect_valid !== 1'b0 || redirect_target !== 32'h99 || flush_if_id !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL squash_back_to_run: loads=%b rv=%b tgt=%h fl=%b expected 11111 0 00000099 0",
                     loads, redirect_valid, redirect_target, flush_if_id);
        end
        step();
    endtask

    task automatic test_squash_dmem();
        do_reset();
        imem_resp = 1'b0; ex_br_taken = 1'b1; ex_br_target = 32'h80;
        step();
        ex_br_taken = 1'b0; ex_br_target = 32'h123;
        imem_resp = 1'b1; dmem_req = 1'b1; dmem_resp = 1'b0;
        @(negedge clk);
        tests_run++;
        if (loads !== 5'b11000 || redirect_valid !== 1'b1 || redirect_target !== 32'h80 || flush_if_id !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL squash_dmem_exit: loads=%b rv=%b tgt=%h fl=%b expected 11000 1 00000080 1",
                     loads, redirect_valid, redirect_target, flush_if_id);
        end
        step();
        @(negedge clk);
        tests_run++;
        if (loads !== 5'b00000 || redirect_valid !== 1'b0 || redirect_target !== 32'h123) begin
            tests_failed++;
            $display("[TB] FAIL squash_dmem_run: loads=%b rv=%b tgt=%h expected 00000 0 00000123",
                     loads, redirect_valid, redirect_target);
        end
        step();
        dmem_req = 1'b0; imem_resp = 1'b0;
        @(negedge clk);
        tests_run++;
        if (loads !== 5'b00111 || bubble_id_ex !== 1'b1 || flush_if_id !== 1'b0 || redirect_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL run_fetch_wait: loads=%b bb=%b fl=%b rv=%b expected 00111 1 0 0",
                     loads, bubble_id_ex, flush_if_id, redirect_valid);
        end
        applyStimulus_idle();
        step();
    endtask

    task automatic test_reset_in_squash();
        do_reset();
        imem_resp = 1'b0; ex_br_taken = 1'b1; ex_br_target = 32'h70;
        step();
        ex_br_taken = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        imem_resp = 1'b1; ex_br_target = 32'h10;
        @(negedge clk);
        tests_run++;
        if (loads !== 5'b11111 || redirect_valid !== 1'b0 || redirect_target !== 32'h10 || stall_count !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_squash: loads=%b rv=%b tgt=%h cnt=%0d expected 11111 0 00000010 0",
                     loads, redirect_valid, redirect_target, stall_count);
        end
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        ex_br_taken = 1'b1; ex_br_target = 32'h200;
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1_used = 1'b1; id_rs1 = 5'd3;
        @(negedge clk);
        tests_run++;
        if (redirect_valid !== 1'b1 || redirect_target !== 32'h200 || loads !== 5'b11111) begin
            tests_failed++;
            $display("[TB] FAIL branch_over_load_use: rv=%b tgt=%h loads=%b expected 1 00000200 11111",
                     redirect_valid, redirect_target, loads);
        end
        step();
        ex_mem_read = 1'b0; ex_br_target = 32'h300;
        @(negedge clk);
        tests_run++;
        if (redirect_valid !== 1'b1 || redirect_target !== 32'h300 || flush_if_id !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL branch_second: rv=%b tgt=%h fl=%b expected 1 00000300 1",
                     redirect_valid, redirect_target, flush_if_id);
        end
        applyStimulus_idle();
        step();
    endtask

    task automatic test_perf_counter();
        do_reset();
        imem_resp = 1'b0;
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        tests_run++;
        if (stall_count !== EXP_CNT3) begin
            tests_failed++;
            $display("[TB] FAIL stall_count_3: got %0d expected %0d", stall_count, EXP_CNT3);
        end
        for (int i = 0; i < 17; i++) step();
        @(negedge clk);
        tests_run++;
        if (stall_count !== EXP_CNT20) begin
            tests_failed++;
            $display("[TB] FAIL stall_count_sat: got %0d expected %0d", stall_count, EXP_CNT20);
        end
        applyStimulus_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (stall_count !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL stall_count_reset: got %0d expected 0", stall_count);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus_idle();
        step();
        test_reset();
        test_load_use();
        test_dmem_stall();
        test_squash();
        test_squash_dmem();
        test_reset_in_squash();
        test_back_to_back();
        test_perf_counter();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
